vga_scan_engine: RTL and testbench

// Parametrised VGA raster engine: programmable timing, pixel-clock prescaler, and a pixel-request interface LEAD ticks ahead of display.

---
 rtl/vga_scan_engine.sv | 184 ++++++++++++++++++
 tb/tb_vga_scan_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: parametrised VGA raster engine.
// A prescaler produces a pixel tick every CLK_DIV clocks. A display counter
// (hx,vy) drives sync, blanking and colour registers, while a fetch counter
// (fx,fy) runs LEAD ticks ahead and issues pixel requests so the frame-buffer
// reader has LEAD ticks to return the colour.
// Optional feature: define VGA_TESTPAT_EN to add a test_mode input that
// replaces visible colour with eight vertical colour bars.
module vga_scan_engine #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CLK_DIV  = 2,
  parameter int   LEAD     = 4,
  parameter int   RED_W    = 3,
  parameter int   GRN_W    = 3,
  parameter int   BLU_W    = 2,
  localparam int  HT       = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  VT       = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW       = $clog2(HT),
  localparam int  VW       = $clog2(VT),
  localparam int  PW       = RED_W + GRN_W + BLU_W
) (
  input  logic             clk,
  input  logic             reset,
`ifdef VGA_TESTPAT_EN
  input  logic             test_mode,
`endif
  output logic             pix_req,
  output logic [HW-1:0]    pix_x,
  output logic [VW-1:0]    pix_y,
  input  logic [PW-1:0]    pix_data,
  output logic [RED_W-1:0] vgaRed,
  output logic [GRN_W-1:0] vgaGreen,
  output logic [BLU_W-1:0] vgaBlue,
  output logic             Hsync,
  output logic             Vsync,
  output logic             frame_start,
  output logic             active
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
  localparam logic [HW-1:0] F_START  = HW'(LEAD);
  // 32-bit bounds so a sync window ending exactly at HT/VT cannot wrap
  localparam logic [31:0] H_VIS  = 32'(H_ACTIVE);
  localparam logic [31:0] V_VIS  = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]    r_div;
  logic [HW-1:0]    r_hx, r_fx, r_px;
  logic [VW-1:0]    r_vy, r_fy, r_py;
  logic             r_req, r_fs, r_act, r_hs, r_vs;
  logic [RED_W-1:0] r_red;
  logic [GRN_W-1:0] r_grn;
  logic [BLU_W-1:0] r_blu;

  logic             w_tick, w_vis, w_fvis, w_hs_on, w_vs_on;
  logic [RED_W-1:0] w_red;
  logic [GRN_W-1:0] w_grn;
  logic [BLU_W-1:0] w_blu;

  assign w_tick  = (r_div == DIV_LAST);
  assign w_vis   = (32'(r_hx) < H_VIS) && (32'(r_vy) < V_VIS);
  assign w_fvis  = (32'(r_fx) < H_VIS) && (32'(r_fy) < V_VIS);
  assign w_hs_on = (32'(r_hx) >= HS_BEG) && (32'(r_hx) < HS_END);
  assign w_vs_on = (32'(r_vy) >= VS_BEG) && (32'(r_vy) < VS_END);

`ifdef VGA_TESTPAT_EN
  logic [2:0] w_bar;
  // Bar index is hx[8:6]; shift-then-resize keeps narrow hx widths legal
  assign w_bar = 3'(r_hx >> 6);
`endif

  // Colour source: frame-buffer data, or colour bars in test mode
  always_comb begin
    w_red = pix_data[PW-1 -: RED_W];
    w_grn = pix_data[GRN_W+BLU_W-1 -: GRN_W];
    w_blu = pix_data[BLU_W-1:0];
`ifdef VGA_TESTPAT_EN
    if (test_mode) begin
      w_red = {RED_W{w_bar[2]}};
      w_grn = {GRN_W{w_bar[1]}};
      w_blu = {BLU_W{w_bar[0]}};
    end
`endif
  end

  // Pixel-tick prescaler: tick on the last count of each CLK_DIV period
  always_ff @(posedge clk) begin
    if (reset || w_tick) r_div <= '0;
    else                 r_div <= r_div + 1'b1;
  end

  // Display position counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hx <= '0;
      r_vy <= '0;
    end else if (w_tick) begin
      if (r_hx == H_LAST) begin
        r_hx <= '0;
        r_vy <= (r_vy == V_LAST) ? '0 : r_vy + 1'b1;
      end else begin
        r_hx <= r_hx + 1'b1;
      end
    end
  end

  // Fetch position counter, starting LEAD ticks ahead of the display counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fx <= F_START;
      r_fy <= '0;
    end else if (w_tick) begin
      if (r_fx == H_LAST) begin
        r_fx <= '0;
        r_fy <= (r_fy == V_LAST) ? '0 : r_fy + 1'b1;
      end else begin
        r_fx <= r_fx + 1'b1;
      end
    end
  end

  // Pixel request: one-clock pulse, coordinates held until the next request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req <= 1'b0;
      r_px  <= '0;
      r_py  <= '0;
    end else begin
      r_req <= w_tick & w_fvis;
      if (w_tick && w_fvis) begin
        r_px <= r_fx;
        r_py <= r_fy;
      end
    end
  end

  // Registered video outputs for the current display position
  always_ff @(posedge clk) begin
    if (reset) begin
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
      r_act <= 1'b0;
      r_fs  <= 1'b0;
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
    end else if (w_tick) begin
      r_red <= w_vis ? w_red : '0;
      r_grn <= w_vis ? w_grn : '0;
      r_blu <= w_vis ? w_blu : '0;
      r_act <= w_vis;
      r_fs  <= (r_hx == '0) && (r_vy == '0);
      r_hs  <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      r_vs  <= w_vs_on ? SYNC_POL : ~SYNC_POL;
    end else begin
      r_fs  <= 1'b0;
    end
  end

  assign pix_req     = r_req;
  assign pix_x       = r_px;
  assign pix_y       = r_py;
  assign vgaRed      = r_red;
  assign vgaGreen    = r_grn;
  assign vgaBlue     = r_blu;
  assign Hsync       = r_hs;
  assign Vsync       = r_vs;
  assign frame_start = r_fs;
  assign active      = r_act;

endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: scoreboard bench for vga_scan_engine on a reduced
// raster (24x10 ticks per frame) with random pixel colours and random
// mid-frame resets. Expected requests and display ticks are derived from the
// tick index since reset release and pushed into queues; a monitor pops them.
module tb_vga_scan_engine;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam logic POL = 1'b0;
  localparam int CD = 2, LEAD = 4;
  localparam int RW = 3, GW = 3, BW = 2, PW = RW + GW + BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] pix_data = '0;
  logic          pix_req, Hsync, Vsync, frame_start, active;
  logic [HW-1:0] pix_x;
  logic [VW-1:0] pix_y;
  logic [RW-1:0] vgaRed;
  logic [GW-1:0] vgaGreen;
  logic [BW-1:0] vgaBlue;
`ifdef VGA_TESTPAT_EN
  logic          test_mode = 1'b0;
`endif

  vga_scan_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(POL), .CLK_DIV(CD), .LEAD(LEAD),
    .RED_W(RW), .GRN_W(GW), .BLU_W(BW)
  ) dut (
    .clk(clk), .reset(reset),
`ifdef VGA_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .Hsync(Hsync), .Vsync(Vsync), .frame_start(frame_start), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int x; int y; } req_t;
  typedef struct { int cyc; logic hs; logic vs; logic act; logic fs; logic dc; logic [PW-1:0] col; } disp_t;
  typedef struct { int due; logic [PW-1:0] d; } pend_t;

  req_t  req_q[$];
  disp_t disp_q[$];
  pend_t pend_q[$];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   salt = 0;
  logic rst_d = 1'b1;

  // Clock-edge counter and the reset value the DUT sampled on that edge
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  function automatic logic [PW-1:0] color_of(int x, int y);
    return PW'((x * 37 + y * 101) ^ salt);
  endfunction

  task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Reference raster: tick k after release shows pixel k mod FT and fetches k+LEAD
  task automatic gen_expect(input int c0, input int nticks);
    for (int k = 0; k < nticks; k++) begin
      disp_t e;
      int c, t, x, y, f, fx, fy;
      logic vis;
      c = c0 + (CD - 1) + k * CD;
      t = k % FT;
      x = t % HT;
      y = t / HT;
      vis = (x < HA) && (y < VA);
      e.cyc = c;
      e.hs  = ((x >= HA + HFP) && (x < HA + HFP + HSW)) ? POL : ~POL;
      e.vs  = ((y >= VA + VFP) && (y < VA + VFP + VSW)) ? POL : ~POL;
      e.act = vis;
      e.fs  = (t == 0);
      e.dc  = vis && (k < LEAD);
      e.col = (vis && k >= LEAD) ? color_of(x, y) : '0;
      disp_q.push_back(e);
      f  = (k + LEAD) % FT;
      fx = f % HT;
      fy = f / HT;
      if (fx < HA && fy < VA) req_q.push_back('{c, fx, fy});
    end
  endtask

  // Requester model: answer each request LEAD ticks later, junk otherwise
  always @(negedge clk) begin
    if (rst_d) pend_q.delete();
    else if (pix_req) pend_q.push_back('{cyc + LEAD * CD, color_of(int'(pix_x), int'(pix_y))});
    if (pend_q.size() > 0 && pend_q[0].due == cyc + 1) pix_data = pend_q.pop_front().d;
    else pix_data = PW'($urandom);
  end

  int   last_fs = 0;
  int   nreq = 0;
  logic have_fs = 1'b0;

  // Monitor: compare DUT outputs against queued expectations
  always @(negedge clk) begin
    if (rst_d) begin
      chk("rst_quiet", 32'({vgaRed, vgaGreen, vgaBlue, active, pix_req, frame_start}), 0);
      chk("rst_sync", 32'({Hsync, Vsync}), 32'({~POL, ~POL}));
      chk("rst_pix", 32'({pix_x, pix_y}), 0);
      have_fs = 1'b0;
      nreq = 0;
    end else begin
      while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
        chk("req_missing", 0, 1);
        void'(req_q.pop_front());
      end
      while (disp_q.size() > 0 && disp_q[0].cyc < cyc) begin
        chk("disp_missing", 0, 1);
        void'(disp_q.pop_front());
      end
      if (frame_start) begin
        if (have_fs) begin
          chk("frame_period", 32'(cyc - last_fs), 32'(FT * CD));
          chk("reqs_per_frame", 32'(nreq), 32'(HA * VA));
        end
        have_fs = 1'b1;
        last_fs = cyc;
        nreq = 0;
      end
      if (pix_req) nreq++;
      if (req_q.size() > 0 && req_q[0].cyc == cyc) begin
        req_t r;
        r = req_q.pop_front();
        chk("req_pulse", 32'(pix_req), 1);
        chk("req_x", 32'(pix_x), 32'(r.x));
        chk("req_y", 32'(pix_y), 32'(r.y));
      end else if (pix_req) begin
        chk("req_spurious", 32'(pix_req), 0);
      end
      if (disp_q.size() > 0 && disp_q[0].cyc == cyc) begin
        disp_t e;
        e = disp_q.pop_front();
        chk("hsync", 32'(Hsync), 32'(e.hs));
        chk("vsync", 32'(Vsync), 32'(e.vs));
        chk("active", 32'(active), 32'(e.act));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        if (!e.dc) chk("colour", 32'({vgaRed, vgaGreen, vgaBlue}), 32'(e.col));
      end else if (frame_start) begin
        chk("fs_spurious", 32'(frame_start), 0);
      end
    end
  end

  task automatic release_and_run(input int nclk);
    reset = 1'b0;
    gen_expect(cyc + 1, 3 * FT);
    repeat (nclk) @(posedge clk);
    #1;
  endtask

  task automatic hit_reset(input int nclk);
    reset = 1'b1;
    // Keep expectations for edges already taken; drop those the reset overrides
    while (req_q.size() > 0 && req_q[req_q.size()-1].cyc > cyc) void'(req_q.pop_back());
    while (disp_q.size() > 0 && disp_q[disp_q.size()-1].cyc > cyc) void'(disp_q.pop_back());
    repeat (nclk) @(posedge clk);
    #1;
  endtask

  initial begin
    salt = int'($urandom);
    repeat (3) @(posedge clk);
    #1;
    release_and_run((2 * FT + 50) * CD);
    for (int i = 0; i < 4; i++) begin
      hit_reset(int'($urandom_range(2, 4)));
      release_and_run(int'($urandom_range(60, 500)));
    end
    hit_reset(3);
    release_and_run(FT * CD + 40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
